// File: rtl/simmem_delay_multibank_if.sv
// Request/release handshake bundle for simmem_delay_multibank.
// slave  : the delay bank side.
// master : the traffic source / response-release side.
interface simmem_delay_multibank_if #(
  parameter int IDWidth      = 4,
  parameter int CounterWidth = 16
);

  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [IDWidth-1:0]        in_id_i;
  logic [CounterWidth-1:0]   in_delay_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [IDWidth-1:0]        out_id_o;
  logic [(2**IDWidth)-1:0]   release_en_o;

  modport slave (
    input  in_valid_i,
    input  in_id_i,
    input  in_delay_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_id_o,
    output release_en_o
  );

  modport master (
    output in_valid_i,
    output in_id_i,
    output in_delay_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_id_o,
    input  release_en_o
  );

endinterface

// File: rtl/simmem_delay_multibank.sv
// simmem_delay_multibank: multi-slot delay bank with per-slot down-counters.
// Each accepted request is held until its delay expires and until every
// earlier request with the same ID has been released; expired requests are
// presented one at a time (lowest slot index first) on a valid/ready port.
//
// Optional feature macro: SIMMEM_DELAY_BANK_OCCUPANCY_EN
//   Adds occupancy_o (registered count of valid slots) and an occupancy
//   checker that flags an accept while the bank is full.
//
// All outputs are registers loaded from the decoded next state, so they
// reflect the current slot contents with no combinational input path.

`ifdef SIMMEM_DELAY_BANK_OCCUPANCY_EN
module simmem_delay_multibank_chk #(
  parameter int NumSlots = 16,
  parameter int OccW     = 5
) (
  input logic            clk_i,
  input logic            rst_i,
  input logic            accept_i,
  input logic [OccW-1:0] occupancy_i
);

  // An accept can never happen while every slot is already occupied.
  a_no_accept_when_full: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(accept_i && (occupancy_i == OccW'(NumSlots)))
  );

endmodule
`endif

module simmem_delay_multibank #(
  parameter int NumSlots     = 16,
  parameter int IDWidth      = 4,
  parameter int CounterWidth = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  simmem_delay_multibank_if.slave          bus_if
`ifdef SIMMEM_DELAY_BANK_OCCUPANCY_EN
  ,
  output logic [$clog2(NumSlots+1)-1:0]    occupancy_o
`endif
);

  localparam int NumIds   = 2 ** IDWidth;
  localparam int SlotIdxW = $clog2(NumSlots);
  localparam int OccW     = $clog2(NumSlots + 1);

  // Slot state
  logic [NumSlots-1:0]     r_valid;
  logic [IDWidth-1:0]      r_id    [NumSlots];
  logic [CounterWidth-1:0] r_cnt   [NumSlots];
  logic [NumSlots-1:0]     r_older [NumSlots];

  // Registered outputs and the slot currently presented
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [IDWidth-1:0]      r_out_id;
  logic [NumIds-1:0]       r_release_en;
  logic [SlotIdxW-1:0]     r_sel_idx;

  // Current-cycle decisions
  logic                    w_accept;
  logic                    w_release;
  logic [NumSlots-1:0]     w_rel_mask;
  logic [SlotIdxW-1:0]     w_free_idx;
  logic [NumSlots-1:0]     w_same_id;

  // Next slot state
  logic [NumSlots-1:0]     w_nxt_valid;
  logic [IDWidth-1:0]      w_nxt_id    [NumSlots];
  logic [CounterWidth-1:0] w_nxt_cnt   [NumSlots];
  logic [NumSlots-1:0]     w_nxt_older [NumSlots];

  // Decoded next outputs
  logic [NumSlots-1:0]     w_nxt_elig;
  logic                    w_nxt_out_valid;
  logic [IDWidth-1:0]      w_nxt_out_id;
  logic [NumIds-1:0]       w_nxt_rel_en;
  logic [SlotIdxW-1:0]     w_nxt_sel;
  logic                    w_nxt_in_ready;

  assign w_accept  = bus_if.in_valid_i & r_in_ready;
  assign w_release = r_out_valid & bus_if.out_ready_i;

  // One-hot of the slot handed to the consumer this cycle.
  always_comb begin
    w_rel_mask = '0;
    if (w_release) begin
      w_rel_mask[r_sel_idx] = 1'b1;
    end else begin
      w_rel_mask = '0;
    end
  end

  // Lowest-index free slot, judged on current state so a slot freed this
  // cycle is not handed out until the next one.
  always_comb begin
    w_free_idx = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_idx = SlotIdxW'(i);
      end else begin
        w_free_idx = w_free_idx;
      end
    end
  end

  // Valid slots that share the incoming ID; these become the new entry's predecessors.
  always_comb begin
    for (int j = 0; j < NumSlots; j++) begin
      w_same_id[j] = r_valid[j] & (r_id[j] == bus_if.in_id_i);
    end
  end

  // Next slot state: count down, retire the released slot, load the new entry.
  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      w_nxt_valid[i] = r_valid[i];
      w_nxt_id[i]    = r_id[i];
      w_nxt_older[i] = r_older[i] & ~w_rel_mask;
      if (r_valid[i] && (r_cnt[i] != {CounterWidth{1'b0}})) begin
        w_nxt_cnt[i] = r_cnt[i] - CounterWidth'(1);
      end else begin
        w_nxt_cnt[i] = r_cnt[i];
      end

      if (w_rel_mask[i]) begin
        w_nxt_valid[i] = 1'b0;
        w_nxt_id[i]    = '0;
        w_nxt_cnt[i]   = '0;
        w_nxt_older[i] = '0;
      end else if (w_accept && (w_free_idx == SlotIdxW'(i))) begin
        // The releasing slot is masked out so the new entry never waits on it.
        w_nxt_valid[i] = 1'b1;
        w_nxt_id[i]    = bus_if.in_id_i;
        w_nxt_cnt[i]   = bus_if.in_delay_i;
        w_nxt_older[i] = w_same_id & ~w_rel_mask;
      end else begin
        w_nxt_valid[i] = w_nxt_valid[i];
      end
    end
  end

  // Eligibility of each slot in the next state.
  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      w_nxt_elig[i] = w_nxt_valid[i]
                    & (w_nxt_cnt[i] == {CounterWidth{1'b0}})
                    & (w_nxt_older[i] == {NumSlots{1'b0}});
    end
  end

  // Lowest-index eligible slot wins; per-ID enables OR over all eligible slots.
  always_comb begin
    w_nxt_out_valid = 1'b0;
    w_nxt_out_id    = '0;
    w_nxt_sel       = '0;
    w_nxt_rel_en    = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (w_nxt_elig[i]) begin
        w_nxt_out_valid            = 1'b1;
        w_nxt_out_id               = w_nxt_id[i];
        w_nxt_sel                  = SlotIdxW'(i);
        w_nxt_rel_en[w_nxt_id[i]]  = 1'b1;
      end else begin
        w_nxt_out_valid = w_nxt_out_valid;
      end
    end
  end

  assign w_nxt_in_ready = ~(&w_nxt_valid);

  // Slot state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        r_id[i]    <= '0;
        r_cnt[i]   <= '0;
        r_older[i] <= '0;
      end
    end else begin
      r_valid <= w_nxt_valid;
      for (int i = 0; i < NumSlots; i++) begin
        r_id[i]    <= w_nxt_id[i];
        r_cnt[i]   <= w_nxt_cnt[i];
        r_older[i] <= w_nxt_older[i];
      end
    end
  end

  // Output registers, loaded from the decoded next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_id     <= '0;
      r_release_en <= '0;
      r_sel_idx    <= '0;
    end else begin
      r_in_ready   <= w_nxt_in_ready;
      r_out_valid  <= w_nxt_out_valid;
      r_out_id     <= w_nxt_out_id;
      r_release_en <= w_nxt_rel_en;
      r_sel_idx    <= w_nxt_sel;
    end
  end

  assign bus_if.in_ready_o   = r_in_ready;
  assign bus_if.out_valid_o  = r_out_valid;
  assign bus_if.out_id_o     = r_out_id;
  assign bus_if.release_en_o = r_release_en;

`ifdef SIMMEM_DELAY_BANK_OCCUPANCY_EN
  logic [OccW-1:0] r_occupancy;
  logic [OccW-1:0] w_nxt_occ;

  // Population count of the next valid vector.
  always_comb begin
    w_nxt_occ = '0;
    for (int i = 0; i < NumSlots; i++) begin
      w_nxt_occ = w_nxt_occ + OccW'(w_nxt_valid[i]);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_occupancy <= '0;
    end else begin
      r_occupancy <= w_nxt_occ;
    end
  end

  assign occupancy_o = r_occupancy;

  simmem_delay_multibank_chk #(
    .NumSlots (NumSlots),
    .OccW     (OccW)
  ) u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .accept_i    (w_accept),
    .occupancy_i (r_occupancy)
  );
`endif

endmodule

// File: tb/tb_simmem_delay_multibank.sv
// Testbench for simmem_delay_multibank: a table of directed vectors with
// constant expectations, hand-written corner sequences, and a randomized run
// checked against a slot/arrival-order reference model using absolute
// expiry times.
module tb_simmem_delay_multibank;

  localparam int NS  = 16;
  localparam int IDW = 4;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simmem_delay_multibank_if #(.IDWidth(IDW), .CounterWidth(CW)) bus ();

`ifdef SIMMEM_DELAY_BANK_OCCUPANCY_EN
  logic [$clog2(NS+1)-1:0] occ;
`endif

  simmem_delay_multibank #(
    .NumSlots     (NS),
    .IDWidth      (IDW),
    .CounterWidth (CW)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus)
`ifdef SIMMEM_DELAY_BANK_OCCUPANCY_EN
    ,
    .occupancy_o (occ)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one record per slot, with arrival sequence number and
  // the edge index at which its delay has run out.
  bit     m_valid [NS];
  int     m_id    [NS];
  longint m_exp   [NS];
  int     m_seq   [NS];
  longint m_edge  = 0;
  int     m_seqcnt = 0;

  function automatic bit m_elig(int s);
    if (!m_valid[s]) return 1'b0;
    if (m_edge < m_exp[s]) return 1'b0;
    for (int j = 0; j < NS; j++)
      if (m_valid[j] && m_id[j] == m_id[s] && m_seq[j] < m_seq[s]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_sel();
    for (int s = 0; s < NS; s++) if (m_elig(s)) return s;
    return -1;
  endfunction

  function automatic logic [15:0] m_rel();
    logic [15:0] r;
    r = 16'h0000;
    for (int s = 0; s < NS; s++) if (m_elig(s)) r[m_id[s]] = 1'b1;
    return r;
  endfunction

  function automatic int m_free();
    for (int s = 0; s < NS; s++) if (!m_valid[s]) return s;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one edge with the given inputs and advance the model alongside.
  task automatic step(input bit r, input bit iv, input int id, input int dly, input bit ordy);
    int sel;
    int fr;
    sel = m_sel();
    fr  = m_free();
    rst             = r;
    bus.in_valid_i  = iv;
    bus.in_id_i     = id[IDW-1:0];
    bus.in_delay_i  = dly[CW-1:0];
    bus.out_ready_i = ordy;
    @(posedge clk);
    m_edge++;
    if (r) begin
      for (int s = 0; s < NS; s++) m_valid[s] = 1'b0;
    end else begin
      if (sel >= 0 && ordy) m_valid[sel] = 1'b0;
      if (iv && fr >= 0) begin
        m_valid[fr] = 1'b1;
        m_id[fr]    = id;
        m_exp[fr]   = m_edge + dly;
        m_seqcnt++;
        m_seq[fr]   = m_seqcnt;
      end
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    int sel;
    sel = m_sel();
    check({tag, "_in_ready"},   bus.in_ready_o,   (m_free() >= 0));
    check({tag, "_out_valid"},  bus.out_valid_o,  (sel >= 0));
    check({tag, "_release_en"}, bus.release_en_o, m_rel());
    if (sel >= 0) check({tag, "_out_id"}, bus.out_id_o, m_id[sel]);
`ifdef SIMMEM_DELAY_BANK_OCCUPANCY_EN
    begin
      int cnt;
      cnt = 0;
      for (int s = 0; s < NS; s++) cnt += m_valid[s];
      check({tag, "_occupancy"}, occ, cnt);
    end
`endif
  endtask

  typedef struct {
    bit rst; bit iv; int id; int dly; bit ordy;
    bit e_rdy; bit e_vld; int e_id; int e_rel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit r, bit iv, int id, int dly, bit ordy,
                             bit e_rdy, bit e_vld, int e_id, int e_rel);
    vec_t x;
    x.rst = r; x.iv = iv; x.id = id; x.dly = dly; x.ordy = ordy;
    x.e_rdy = e_rdy; x.e_vld = e_vld; x.e_id = e_id; x.e_rel = e_rel;
    return x;
  endfunction

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_id_i     = '0;
    bus.in_delay_i  = '0;
    bus.out_ready_i = 1'b0;

    // Reset, and an offer during reset must be ignored.
    vecs.push_back(v(1, 0, 0, 0, 0,  1, 0, 0, 'h0000));
    vecs.push_back(v(1, 1, 7, 0, 0,  1, 0, 0, 'h0000));
    // ID 3 delay 5 at edge 0: eligible in cycle 6, released at edge 6.
    vecs.push_back(v(0, 1, 3, 5, 0,  1, 0, 0, 'h0000));
    for (int k = 0; k < 4; k++) vecs.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 'h0000));
    vecs.push_back(v(0, 0, 0, 0, 0,  1, 1, 3, 'h0008));
    vecs.push_back(v(0, 0, 0, 0, 1,  1, 0, 0, 'h0000));
    // IDs 2 and 5 with zero delay; then two handshakes.
    vecs.push_back(v(0, 1, 2, 0, 0,  1, 1, 2, 'h0004));
    vecs.push_back(v(0, 1, 5, 0, 0,  1, 1, 2, 'h0024));
    vecs.push_back(v(0, 0, 0, 0, 1,  1, 1, 5, 'h0020));
    vecs.push_back(v(0, 0, 0, 0, 1,  1, 0, 0, 'h0000));
    // ID 1 delay 10 then ID 1 delay 2: the short one waits for the long one.
    vecs.push_back(v(0, 1, 1, 10, 0, 1, 0, 0, 'h0000));
    vecs.push_back(v(0, 1, 1, 2, 0,  1, 0, 0, 'h0000));
    for (int k = 0; k < 8; k++) vecs.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 'h0000));
    vecs.push_back(v(0, 0, 0, 0, 0,  1, 1, 1, 'h0002));
    vecs.push_back(v(0, 0, 0, 0, 1,  1, 1, 1, 'h0002));
    vecs.push_back(v(0, 0, 0, 0, 1,  1, 0, 0, 'h0000));

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].iv, vecs[k].id, vecs[k].dly, vecs[k].ordy);
      check($sformatf("vec%0d_in_ready", k),   bus.in_ready_o,   vecs[k].e_rdy);
      check($sformatf("vec%0d_out_valid", k),  bus.out_valid_o,  vecs[k].e_vld);
      check($sformatf("vec%0d_release_en", k), bus.release_en_o, vecs[k].e_rel);
      if (vecs[k].e_vld) check($sformatf("vec%0d_out_id", k), bus.out_id_o, vecs[k].e_id);
      else if (vecs[k].rst) check($sformatf("vec%0d_out_id_rst", k), bus.out_id_o, 0);
    end

    // Fill all slots; the extra offer is refused; one release frees a slot.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < NS; i++) begin
      step(0, 1, i, 100, 0);
      check_model("fill");
    end
    check("fill_full_in_ready", bus.in_ready_o, 0);
    step(0, 1, 5, 0, 0);
    check_model("fill_extra");
    check("fill_extra_in_ready", bus.in_ready_o, 0);
    begin
      int guard;
      guard = 0;
      while (!bus.out_valid_o && guard < 200) begin
        step(0, 0, 0, 0, 0);
        check_model("fill_wait");
        guard++;
      end
    end
    check("fill_wait_valid", bus.out_valid_o, 1);
    check("fill_first_id", bus.out_id_o, 0);
    step(0, 1, 9, 3, 1);
    check("fill_release_in_ready", bus.in_ready_o, 1);
    check_model("fill_release");

    // Release and re-accept the same ID in one cycle.
    step(1, 0, 0, 0, 0);
    step(0, 1, 4, 0, 0);
    check("same_first_id", bus.release_en_o, 'h0010);
    step(0, 1, 4, 0, 1);
    check("same_new_valid", bus.out_valid_o, 1);
    check("same_new_id", bus.out_id_o, 4);
    check("same_new_rel", bus.release_en_o, 'h0010);
    check_model("same");
    step(0, 0, 0, 0, 1);
    check("same_drained", bus.out_valid_o, 0);

    // Reset with eight entries pending; nothing stale may appear afterwards.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, $urandom_range(0, 15), $urandom_range(0, 3), 0);
      check_model("pend");
    end
    step(1, 1, 3, 0, 1);
    check("midrst_in_ready", bus.in_ready_o, 1);
    check("midrst_out_valid", bus.out_valid_o, 0);
    check("midrst_out_id", bus.out_id_o, 0);
    check("midrst_release_en", bus.release_en_o, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 1);
      check("midrst_no_stale", bus.out_valid_o, 0);
    end

    // Randomized traffic against the reference model.
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      bit r;
      bit iv;
      bit ordy;
      r    = ($urandom_range(0, 499) == 0);
      iv   = ($urandom_range(0, 99) < 60);
      ordy = ($urandom_range(0, 99) < ((c < 1500) ? 30 : 80));
      step(r, iv, $urandom_range(0, 3), $urandom_range(0, 12), ordy);
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
